fetch_skid_reg: RTL
===================

FETCH_SKID_REG -- requirements
Module: fetch_skid_reg

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of instruction and PC datapaths.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port flush  input  1  synchronous pipeline flush (branch/jump redirect), active-high.
REQ-005 SHALL have port valid_f  input  1  fetch/icache presents an instruction.
REQ-006 SHALL have port instr_f  input  DATA_WIDTH  fetched instruction.
REQ-007 SHALL have port PC_f  input  DATA_WIDTH  PC of fetched instruction.
REQ-008 SHALL have port PCPlus4_f  input  DATA_WIDTH  PC+4 of fetched instruction.
REQ-009 SHALL have port ready_f  output  1  block can accept an instruction this cycle.
REQ-010 SHALL have port en  input  1  decode consumes output this cycle (low = stall).
REQ-011 SHALL have ports valid_d, instr_d, PC_d, PCPlus4_d  output  1/DATA_WIDTH x3  instruction presented to decode.

Function
REQ-012 SHALL transfer upstream when valid_f && ready_f, downstream when valid_d && en.
REQ-013 SHALL hold a main entry (drives *_d) and a skid entry; state EMPTY (none valid), MAIN (main only), SKID (both).
REQ-014 SHALL drive ready_f = 1 in EMPTY and MAIN, 0 in SKID; ready_f is a register output, not a function of en.
REQ-015 EMPTY: on upstream transfer load main, go MAIN.
REQ-016 MAIN: downstream only -> EMPTY; upstream only -> load skid, go SKID; both -> load main with new instruction, stay MAIN.
REQ-017 SKID: downstream transfer -> move skid into main, go MAIN; no upstream transfer possible.
REQ-018 SHALL give latency of one cycle from upstream transfer to valid_d when EMPTY.
REQ-019 SHALL preserve program order; no instruction dropped or duplicated absent flush.
REQ-020 flush SHALL, at the next edge, invalidate both entries, go EMPTY, drive instr_d = NOP (0x00000013), PC_d = PCPlus4_d = 0, and discard any simultaneous upstream transfer.
REQ-021 flush SHALL take priority over en and valid_f.
REQ-022 SHALL drive instr_d = NOP whenever valid_d = 0.
REQ-023 SHALL hold *_d stable while valid_d && !en.

Reset
REQ-024 rst_n low SHALL immediately force EMPTY, valid_d = 0, instr_d = NOP, PC_d = PCPlus4_d = 0, skid entry cleared, ready_f = 0.
REQ-025 ready_f SHALL rise at the first edge after rst_n deasserts; reset mid-operation discards all held instructions.

Configuration
REQ-026 Macro FETCH_SKID_EN defined: two-entry behaviour as REQ-013..REQ-017.
REQ-027 FETCH_SKID_EN undefined: skid entry and SKID state absent; ready_f = !valid_d || en (combinational); MAIN with simultaneous transfers reloads main; all other requirements unchanged.

Structure
REQ-028 Shared package riscv_pipe_pkg SHALL hold NOP constant (0x00000013), state enum type (EMPTY/MAIN/SKID), and a packed fetch-entry struct (instr, PC, PCPlus4).
REQ-029 Per-entry storage SHALL be sub-module fetch_entry_reg (load, clear, async reset), instantiated for main and skid.

Verification
REQ-030 Reset then valid_f=1, instr_f=0x00500093, PC_f=0x0, en=1 -> next cycle valid_d=1, instr_d=0x00500093, PC_d=0x0, PCPlus4_d=0x4.
REQ-031 Stream 4 instrs PC 0x0..0xC, en held 0 from cycle 2 for 3 cycles -> ready_f=0 after skid fills, *_d stable, resumed output order 0x0,0x4,0x8,0xC, none lost.
REQ-032 In SKID, flush=1 with valid_f=1, PC_f=0x40 -> next cycle valid_d=0, instr_d=0x00000013, ready_f=1; 0x40 not presented.
REQ-033 Continuous valid_f and en=1, PC 0x100..0x11C -> one instruction per cycle, valid_d never drops after first.
REQ-034 rst_n low asynchronously mid-cycle while SKID -> valid_d=0 and instr_d=0x00000013 before next edge.
REQ-035 Repeat REQ-031 with FETCH_SKID_EN undefined -> ready_f tracks en combinationally, same output order.

Source files
------------

// File: rtl/riscv_pipe_pkg.sv
// Shared fetch/decode pipeline definitions: NOP encoding, fetch-buffer
// state type and the packed fetch-entry layout.
package riscv_pipe_pkg;

    localparam int          XLEN = 32;
    localparam logic [31:0] NOP  = 32'h0000_0013;  // addi x0, x0, 0

    typedef enum logic [1:0] {
        EMPTY = 2'd0,   // no entry valid
        MAIN  = 2'd1,   // main entry valid, drives decode
        SKID  = 2'd2    // main and skid both valid, upstream blocked
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] PC;
        logic [XLEN-1:0] PCPlus4;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_entry_reg.sv
// One fetch-buffer entry (instruction, PC, PC+4). Clear wins over load and
// returns the entry to the bubble pattern (NOP, zero PCs) so an empty slot
// never shows a stale instruction.
module fetch_entry_reg
    import riscv_pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] instr_ld,
    input  logic [DATA_WIDTH-1:0] PC_ld,
    input  logic [DATA_WIDTH-1:0] PCPlus4_ld,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] PC,
    output logic [DATA_WIDTH-1:0] PCPlus4
);

    localparam logic [DATA_WIDTH-1:0] NOP_W = DATA_WIDTH'(NOP);

    // Entry storage: reset/clear to bubble, otherwise capture on load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr   <= NOP_W;
            PC      <= '0;
            PCPlus4 <= '0;
        end else if (clear) begin
            instr   <= NOP_W;
            PC      <= '0;
            PCPlus4 <= '0;
        end else if (load) begin
            instr   <= instr_ld;
            PC      <= PC_ld;
            PCPlus4 <= PCPlus4_ld;
        end
    end

endmodule

// File: rtl/fetch_skid_reg.sv
// Fetch-to-decode pipeline register with optional skid entry.
// FETCH_SKID_EN defined: two entries (main + skid), ready_f is registered so
//   the icache never sees a combinational path from decode's stall.
// FETCH_SKID_EN undefined: single main entry, ready_f = !valid_d || en.
// valid_d is the FSM's "not EMPTY" decode, so it is a flop output; the main
// entry is cleared whenever it empties, keeping instr_d = NOP when invalid.
module fetch_skid_reg
    import riscv_pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  valid_f,
    input  logic [DATA_WIDTH-1:0] instr_f,
    input  logic [DATA_WIDTH-1:0] PC_f,
    input  logic [DATA_WIDTH-1:0] PCPlus4_f,
    output logic                  ready_f,
    input  logic                  en,
    output logic                  valid_d,
    output logic [DATA_WIDTH-1:0] instr_d,
    output logic [DATA_WIDTH-1:0] PC_d,
    output logic [DATA_WIDTH-1:0] PCPlus4_d
);

    fetch_state_t state, state_nxt;

    logic up;            // upstream transfer this cycle
    logic dn;            // downstream transfer this cycle
    logic main_load;
    logic main_clear;
    logic [DATA_WIDTH-1:0] main_instr_ld, main_PC_ld, main_PCPlus4_ld;

    assign valid_d = (state != EMPTY);
    assign up      = valid_f && ready_f;
    assign dn      = valid_d && en;

`ifdef FETCH_SKID_EN
    logic ready_q;
    logic skid_load;
    logic skid_clear;
    logic main_from_skid;
    logic [DATA_WIDTH-1:0] skid_instr, skid_PC, skid_PCPlus4;

    assign ready_f = ready_q;

    // State register; ready_f is precomputed from the next state so it is a
    // pure flop output that only falls when the skid entry fills.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= EMPTY;
            ready_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            ready_q <= (state_nxt != SKID);
        end
    end

    assign main_instr_ld   = main_from_skid ? skid_instr   : instr_f;
    assign main_PC_ld      = main_from_skid ? skid_PC      : PC_f;
    assign main_PCPlus4_ld = main_from_skid ? skid_PCPlus4 : PCPlus4_f;
`else
    logic run_q;         // low until the first edge after reset release

    assign ready_f = run_q && (!valid_d || en);

    // State register plus out-of-reset flag that gates ready_f.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
            run_q <= 1'b0;
        end else begin
            state <= state_nxt;
            run_q <= 1'b1;
        end
    end

    assign main_instr_ld   = instr_f;
    assign main_PC_ld      = PC_f;
    assign main_PCPlus4_ld = PCPlus4_f;
`endif

    // Next-state: flush wins; otherwise track the number of held entries.
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: if (up) state_nxt = MAIN;
`ifdef FETCH_SKID_EN
                MAIN: begin
                    if (up && !dn)      state_nxt = SKID;
                    else if (dn && !up) state_nxt = EMPTY;
                end
                SKID: if (dn) state_nxt = MAIN;
`else
                MAIN: if (dn && !up) state_nxt = EMPTY;
`endif
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // Entry control: flush discards everything including a concurrent fetch.
    always_comb begin
        main_load  = 1'b0;
        main_clear = 1'b0;
`ifdef FETCH_SKID_EN
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        main_from_skid = 1'b0;
`endif
        if (flush) begin
            main_clear = 1'b1;
`ifdef FETCH_SKID_EN
            skid_clear = 1'b1;
`endif
        end else begin
            case (state)
                EMPTY: main_load = up;
                MAIN: begin
                    if (up && dn) main_load  = 1'b1;
                    else if (dn)  main_clear = 1'b1;
`ifdef FETCH_SKID_EN
                    else if (up)  skid_load  = 1'b1;
`endif
                end
`ifdef FETCH_SKID_EN
                SKID: begin
                    if (dn) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clear     = 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    fetch_entry_reg #(.DATA_WIDTH(DATA_WIDTH)) u_main (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (main_load),
        .clear      (main_clear),
        .instr_ld   (main_instr_ld),
        .PC_ld      (main_PC_ld),
        .PCPlus4_ld (main_PCPlus4_ld),
        .instr      (instr_d),
        .PC         (PC_d),
        .PCPlus4    (PCPlus4_d)
    );

`ifdef FETCH_SKID_EN
    fetch_entry_reg #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (skid_load),
        .clear      (skid_clear),
        .instr_ld   (instr_f),
        .PC_ld      (PC_f),
        .PCPlus4_ld (PCPlus4_f),
        .instr      (skid_instr),
        .PC         (skid_PC),
        .PCPlus4    (skid_PCPlus4)
    );
`endif

endmodule
